// File: rtl/clk_div_mon_pkg.sv
// Shared types and limits for the divided-clock monitor.
package clk_div_mon_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} mon_state_e;

  localparam int SYNC_MAX = 3;

endpackage

// File: rtl/edge_sync_detect.sv
// Synchronises the divided clock into the clk domain and flags its rising edges.
module edge_sync_detect
  import clk_div_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  if (SYNC_STAGES < 1 || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
    $error("edge_sync_detect: SYNC_STAGES must be 1..%0d", SYNC_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock and tracks lock against an
// expected period, with sticky mismatch and timeout flags.
//
//   state   | meaning
//   IDLE    | disabled, counters cleared, no lock
//   ACQUIRE | waiting for the first rising edge to start counting
//   TRACK   | capturing periods, counting consecutive matches
//   LOCKED  | LOCK_COUNT matches seen; any mismatch drops back to TRACK
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             div_clk_i,
  input  logic [CNT_W-1:0] exp_period_i,
  input  logic [1:0]       tol_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             lock_o,
  output logic             err_mismatch_o,
  output logic             err_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);

  mon_state_e       state_q;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [MC_W-1:0]  match_cnt;
  logic [CNT_W:0]   diff;
  logic             s;
  logic             rise;
  logic             run;
  logic             measuring;
  logic             capture;
  logic             timeout;
  logic             match;
  logic             set_mismatch;

  edge_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync_detect (
    .clk (clk),
    .rst (rst),
    .din (div_clk_i),
    .s   (s),
    .rise(rise)
  );

  assign run          = enable_i && (state_q != IDLE);
  assign measuring    = run && ((state_q == TRACK) || (state_q == LOCKED));
  assign capture      = measuring && rise;
  // A rise on a saturated count is still a legal 2^CNT_W-1 period.
  assign timeout      = measuring && !rise && (pcnt == CNT_MAX);
  assign set_mismatch = capture && !match && (state_q == LOCKED);

  always_comb begin
    if (pcnt >= exp_period_i) begin
      diff = {1'b0, pcnt} - {1'b0, exp_period_i};
    end else begin
      diff = {1'b0, exp_period_i} - {1'b0, pcnt};
    end
  end

  assign match = diff <= {{(CNT_W-1){1'b0}}, tol_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (!run) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      pcnt <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (pcnt != CNT_MAX) pcnt <= pcnt + CNT_W'(1);
      if (s && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_o    <= 1'b0;
      match_cnt <= '0;
    end else if (!enable_i) begin
      state_q   <= IDLE;
      lock_o    <= 1'b0;
      match_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= ACQUIRE;
        ACQUIRE: begin
          if (rise) begin
            state_q   <= TRACK;
            match_cnt <= '0;
          end
        end
        TRACK: begin
          if (timeout) begin
            state_q <= ACQUIRE;
            lock_o  <= 1'b0;
          end else if (capture) begin
            if (!match) begin
              match_cnt <= '0;
            end else if ((match_cnt + MC_W'(1)) == MC_LOCK) begin
              match_cnt <= MC_LOCK;
              state_q   <= LOCKED;
              lock_o    <= 1'b1;
            end else begin
              match_cnt <= match_cnt + MC_W'(1);
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_q <= ACQUIRE;
            lock_o  <= 1'b0;
          end else if (capture && !match) begin
            state_q   <= TRACK;
            lock_o    <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          lock_o  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
    end else begin
      meas_valid_o <= capture;
      if (capture) begin
        period_o <= pcnt;
        high_o   <= hcnt;
      end
    end
  end

  // Set beats clear when both arrive in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mismatch_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      if (set_mismatch)   err_mismatch_o <= 1'b1;
      else if (err_clr_i) err_mismatch_o <= 1'b0;
      if (timeout)        err_timeout_o  <= 1'b1;
      else if (err_clr_i) err_timeout_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a clk-locked divided-clock generator
// pushes each completed period, a monitor pops it on every meas_valid_o pulse.
`timescale 1ns/1ps
module tb_clk_div_monitor;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_i;
  logic             div_clk_i;
  logic [CNT_W-1:0] exp_period_i;
  logic [1:0]       tol_i;
  logic             err_clr_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid_o;
  logic             lock_o;
  logic             err_mismatch_o;
  logic             err_timeout_o;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .LOCK_COUNT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .div_clk_i     (div_clk_i),
    .exp_period_i  (exp_period_i),
    .tol_i         (tol_i),
    .err_clr_i     (err_clr_i),
    .period_o      (period_o),
    .high_o        (high_o),
    .meas_valid_o  (meas_valid_o),
    .lock_o        (lock_o),
    .err_mismatch_o(err_mismatch_o),
    .err_timeout_o (err_timeout_o)
  );

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   gen_ratio  = 4;
  int   gen_high   = 2;
  bit   gen_hold   = 1'b1;
  bit   fresh      = 1'b1;
  int   meas_cnt   = 0;
  int   last_exp_p = 0;
  int   cyc        = 0;
  int   last_mv    = 0;
  bit   mv_prev_ok = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_meas(input int n);
    int seen = 0;
    int c    = 0;
    while (seen < n && c < 2000) begin
      @(negedge clk);
      c++;
      if (meas_valid_o) seen++;
    end
    if (seen < n) check_val("meas_wait_expired", seen, n);
  endtask

  task automatic wait_period(input int p);
    int k = 0;
    do begin
      wait_meas(1);
      k++;
    end while (last_exp_p != p && k < 8);
    check_val("reach_period", last_exp_p, p);
  endtask

  task automatic release_gen();
    mv_prev_ok = 1'b0;
    gen_hold   = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    cycles(1);
    err_clr_i = 1'b0;
  endtask

  // Generator: a period is only scored once a following rise closes it.
  initial begin : gen
    int cur_r;
    int cur_h;
    int prev_r;
    int prev_h;
    exp_t e;
    div_clk_i = 1'b0;
    prev_r = 0;
    prev_h = 0;
    forever begin
      @(negedge clk);
      if (gen_hold) begin
        div_clk_i = 1'b0;
        fresh     = 1'b1;
      end else begin
        cur_r = gen_ratio;
        cur_h = gen_high;
        div_clk_i = 1'b1;
        if (!fresh) begin
          e.p = prev_r;
          e.h = prev_h;
          sb_q.push_back(e);
        end
        fresh  = 1'b0;
        prev_r = cur_r;
        prev_h = cur_h;
        for (int i = 1; i < cur_r; i++) begin
          @(negedge clk);
          div_clk_i = (i < cur_h);
        end
      end
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && meas_valid_o) begin
        meas_cnt++;
        check_val("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          last_exp_p = e.p;
          check_val("period", period_o, e.p);
          check_val("high", high_o, e.h);
          if (mv_prev_ok) check_val("meas_gap", cyc - last_mv, e.p);
        end
        mv_prev_ok = 1'b1;
        last_mv    = cyc;
      end
    end
  end

  initial begin : main
    int snap;
    int c;
    rst = 1'b1;
    enable_i = 1'b0;
    err_clr_i = 1'b0;
    exp_period_i = 8'd4;
    tol_i = 2'd0;
    cycles(3);
    check_val("rst_period", period_o, 0);
    check_val("rst_high", high_o, 0);
    check_val("rst_valid", meas_valid_o, 0);
    check_val("rst_lock", lock_o, 0);
    check_val("rst_mm", err_mismatch_o, 0);
    check_val("rst_to", err_timeout_o, 0);
    rst = 1'b0;
    enable_i = 1'b1;
    cycles(4);

    // divide-by-4 lock
    gen_ratio = 4;
    gen_high = 2;
    release_gen();
    wait_meas(3);
    check_val("d4_lock_early", lock_o, 0);
    wait_meas(1);
    check_val("d4_lock", lock_o, 1);
    check_val("d4_mm", err_mismatch_o, 0);
    check_val("d4_to", err_timeout_o, 0);
    wait_meas(2);
    check_val("d4_lock_hold", lock_o, 1);

    // source changes to divide-by-6 while expecting 4
    gen_ratio = 6;
    gen_high = 3;
    wait_period(6);
    check_val("d6_mm_set", err_mismatch_o, 1);
    check_val("d6_lock_drop", lock_o, 0);
    wait_meas(4);
    check_val("d6_no_relock", lock_o, 0);
    exp_period_i = 8'd6;
    wait_meas(3);
    check_val("d6_relock_early", lock_o, 0);
    wait_meas(1);
    check_val("d6_relock", lock_o, 1);

    pulse_clr();
    check_val("clr_mm", err_mismatch_o, 0);

    // tolerance boundary: |6-5| <= 1
    exp_period_i = 8'd5;
    tol_i = 2'd1;
    wait_meas(3);
    check_val("tol1_lock", lock_o, 1);
    check_val("tol1_mm", err_mismatch_o, 0);

    // clear held across a mismatching capture: set wins
    tol_i = 2'd0;
    err_clr_i = 1'b1;
    wait_meas(1);
    check_val("set_wins_mm", err_mismatch_o, 1);
    check_val("set_wins_lock", lock_o, 0);
    err_clr_i = 1'b0;
    exp_period_i = 8'd6;
    wait_meas(4);
    check_val("relock_6", lock_o, 1);
    pulse_clr();
    check_val("clr_mm2", err_mismatch_o, 0);

    // timeout: hold div_clk low
    gen_hold = 1'b1;
    cycles(200);
    check_val("to_early", err_timeout_o, 0);
    check_val("to_early_lock", lock_o, 1);
    cycles(80);
    check_val("to_set", err_timeout_o, 1);
    check_val("to_lock", lock_o, 0);
    check_val("to_period_hold", period_o, 6);
    release_gen();
    wait_meas(3);
    check_val("to_relock_early", lock_o, 0);
    wait_meas(1);
    check_val("to_relock", lock_o, 1);
    check_val("to_relock_mm", err_mismatch_o, 0);
    pulse_clr();
    check_val("clr_to", err_timeout_o, 0);

    // disable holds results, then divide-by-3 with 2-high duty
    gen_hold = 1'b1;
    cycles(16);
    enable_i = 1'b0;
    cycles(2);
    check_val("dis_lock", lock_o, 0);
    check_val("dis_period", period_o, 6);
    check_val("dis_high", high_o, 3);
    exp_period_i = 8'd3;
    gen_ratio = 3;
    gen_high = 2;
    enable_i = 1'b1;
    cycles(4);
    release_gen();
    wait_meas(3);
    check_val("d3_lock_early", lock_o, 0);
    wait_meas(1);
    check_val("d3_lock", lock_o, 1);
    check_val("d3_mm", err_mismatch_o, 0);

    // async reset mid-TRACK
    gen_hold = 1'b1;
    cycles(16);
    enable_i = 1'b0;
    gen_ratio = 8;
    gen_high = 4;
    exp_period_i = 8'd8;
    cycles(2);
    enable_i = 1'b1;
    cycles(3);
    release_gen();
    wait_meas(2);
    check_val("trk_lock", lock_o, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_period", period_o, 0);
    check_val("arst_high", high_o, 0);
    check_val("arst_valid", meas_valid_o, 0);
    check_val("arst_lock", lock_o, 0);
    check_val("arst_mm", err_mismatch_o, 0);
    check_val("arst_to", err_timeout_o, 0);
    gen_hold = 1'b1;
    cycles(12);
    sb_q.delete();
    mv_prev_ok = 1'b0;
    rst = 1'b0;
    cycles(3);
    snap = meas_cnt;
    release_gen();
    c = 0;
    while (!div_clk_i && c < 20) begin
      @(negedge clk);
      c++;
    end
    cycles(6);
    check_val("first_rise_no_cap", meas_cnt, snap);
    wait_meas(1);
    check_val("second_rise_cap", meas_cnt, snap + 1);
    check_val("post_rst_lock", lock_o, 0);

    gen_hold = 1'b1;
    cycles(20);
    check_val("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
